// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register with a direct-mapped BTB and 2-bit direction counters.
// Predicts the next fetch PC each cycle and redirects on execute-stage mispredicts.
module pc_predict_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic            ex_branch,
  input  logic            ex_cond,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic            misaligned
);

  localparam int unsigned     IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned     TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic            btb_valid  [BTB_ENTRIES];
  logic [TAGW-1:0] btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0] btb_target [BTB_ENTRIES];
  logic            btb_jump   [BTB_ENTRIES];
  logic [1:0]      btb_ctr    [BTB_ENTRIES];

  logic [IDX-1:0]  f_idx;
  logic            f_hit;
  logic [XLEN-1:0] pc_plus4;

  logic [IDX-1:0]  e_idx;
  logic [TAGW-1:0] e_tag;
  logic            e_hit;
  logic            actual_taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] res_target;
  logic            btb_we;
  logic [1:0]      ctr_next;

  // Fetch-side lookup reads the pre-write contents of the array.
  always_comb begin
    f_idx       = pc[IDX+1:2];
    pc_plus4    = pc + FOUR;
    f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == pc[XLEN-1:IDX+2]);
    pred_taken  = f_hit && (btb_jump[f_idx] || btb_ctr[f_idx][1]);
    pred_target = f_hit ? btb_target[f_idx] : pc_plus4;
  end

  always_comb begin
    actual_taken = ex_jump || (ex_branch && ex_cond);
    jalr_sum     = ex_rs1 + ex_imm;
    if (!actual_taken)
      res_target = ex_pc + FOUR;
    else if (ex_jump && ex_jalr)
      res_target = {jalr_sum[XLEN-1:1], 1'b0};
    else
      res_target = ex_pc + ex_imm;
    redirect   = ex_valid && ((actual_taken != ex_pred_taken) ||
                              (actual_taken && (res_target != ex_pred_target)));
    misaligned = ex_valid && actual_taken && res_target[1];
  end

  always_comb begin
    e_idx  = ex_pc[IDX+1:2];
    e_tag  = ex_pc[XLEN-1:IDX+2];
    e_hit  = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
    btb_we = ex_valid && (ex_jump || ex_branch);
    ctr_next = btb_ctr[e_idx];
    if (actual_taken) begin
      if (btb_ctr[e_idx] != 2'b11) ctr_next = btb_ctr[e_idx] + 2'b01;
    end else begin
      if (btb_ctr[e_idx] != 2'b00) ctr_next = btb_ctr[e_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (redirect)
      pc <= res_target;
    else if (!stall)
      pc <= pred_taken ? pred_target : pc_plus4;
  end

  // Only the valid bits are reset; payload fields are rewritten on allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '{default: 1'b0};
    end else if (btb_we) begin
      if (e_hit) begin
        if (actual_taken) btb_target[e_idx] <= res_target;
        btb_jump[e_idx] <= ex_jump;
        if (ex_branch) btb_ctr[e_idx] <= ctr_next;
      end else if (actual_taken) begin
        btb_valid[e_idx]  <= 1'b1;
        btb_tag[e_idx]    <= e_tag;
        btb_target[e_idx] <= res_target;
        btb_jump[e_idx]   <= ex_jump;
        btb_ctr[e_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: an abstract BTB/PC model checked every cycle,
// plus hand-computed expectations along the stimulus sequence.
module tb_pc_predict_unit;

  localparam int unsigned N = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] pc, pred_target;
  logic        pred_taken;
  logic        ex_valid, ex_jump, ex_jalr, ex_branch, ex_cond, ex_pred_taken;
  logic [31:0] ex_pc, ex_rs1, ex_imm, ex_pred_target;
  logic        redirect, misaligned;

  int n_pass = 0;
  int n_total = 0;

  pc_predict_unit #(.XLEN(32), .RESET_PC(RST_PC), .BTB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc(pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_branch(ex_branch),
    .ex_cond(ex_cond), .ex_rs1(ex_rs1), .ex_imm(ex_imm),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Abstract model: a table of entries addressed by word number modulo N.
  bit          m_init = 0;
  bit [31:0]   m_pc;
  bit          m_v   [N];
  bit [31:0]   m_tag [N];
  bit [31:0]   m_tgt [N];
  bit          m_isj [N];
  int          m_ctr [N];

  always @(negedge clk) begin
    int unsigned fi, ei;
    bit          fhit, ehit, e_pt, taken, e_redir, e_mis;
    bit [31:0]   e_ptgt, dest;
    if (m_init) begin
      fi     = (m_pc / 4) % N;
      fhit   = m_v[fi] && (m_tag[fi] == m_pc / (4 * N));
      e_pt   = fhit && (m_isj[fi] || m_ctr[fi] >= 2);
      e_ptgt = fhit ? m_tgt[fi] : m_pc + 4;
      chk("model_pc", pc, m_pc);
      chk("model_pred_taken", 32'(pred_taken), 32'(e_pt));
      chk("model_pred_target", pred_target, e_ptgt);
    end
    taken = ex_jump || (ex_branch && ex_cond);
    if (!taken) dest = ex_pc + 4;
    else if (ex_jump && ex_jalr) dest = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    else dest = ex_pc + ex_imm;
    e_redir = ex_valid && ((taken != ex_pred_taken) || (taken && dest != ex_pred_target));
    e_mis   = ex_valid && taken && dest[1];
    chk("model_redirect", 32'(redirect), 32'(e_redir));
    chk("model_misaligned", 32'(misaligned), 32'(e_mis));
    if (rst) begin
      m_init = 1;
      m_pc   = RST_PC;
      for (int i = 0; i < N; i++) m_v[i] = 0;
    end else if (m_init) begin
      if (e_redir) m_pc = dest;
      else if (!stall) m_pc = e_pt ? e_ptgt : m_pc + 4;
      if (ex_valid && (ex_jump || ex_branch)) begin
        ei   = (ex_pc / 4) % N;
        ehit = m_v[ei] && (m_tag[ei] == ex_pc / (4 * N));
        if (ehit) begin
          if (taken) m_tgt[ei] = dest;
          m_isj[ei] = ex_jump;
          if (ex_branch) m_ctr[ei] = taken ? (m_ctr[ei] < 3 ? m_ctr[ei] + 1 : 3)
                                           : (m_ctr[ei] > 0 ? m_ctr[ei] - 1 : 0);
        end else if (taken) begin
          m_v[ei] = 1; m_tag[ei] = ex_pc / (4 * N); m_tgt[ei] = dest;
          m_isj[ei] = ex_jump; m_ctr[ei] = 2;
        end
      end
    end
  end

  task automatic ex_idle();
    ex_valid = 0; ex_jump = 0; ex_jalr = 0; ex_branch = 0; ex_cond = 0;
    ex_pc = '0; ex_rs1 = '0; ex_imm = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1 ex_idle();
    #1;
  endtask

  task automatic ex_br(input logic [31:0] a, input logic [31:0] imm, input logic cond,
                       input logic pt, input logic [31:0] ptgt);
    ex_idle();
    ex_valid = 1; ex_branch = 1; ex_pc = a; ex_imm = imm; ex_cond = cond;
    ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic ex_jmp(input logic [31:0] a, input logic jalr, input logic [31:0] rs1,
                        input logic [31:0] imm);
    ex_idle();
    ex_valid = 1; ex_jump = 1; ex_jalr = jalr; ex_pc = a; ex_rs1 = rs1; ex_imm = imm;
    #1;
  endtask

  // Steer fetch to addr via a stale-alias prediction on the preceding word.
  task automatic goto_pc(input logic [31:0] addr);
    ex_idle();
    ex_valid = 1; ex_pc = addr - 32'd4; ex_pred_taken = 1; ex_pred_target = 32'hDEAD_0000;
    #1 chk("alias_redirect", 32'(redirect), 32'd1);
    step();
    chk("goto_pc", pc, addr);
  endtask

  initial begin
    rst = 1; stall = 0;
    ex_idle();
    step(); step();
    rst = 0;
    #1;
    chk("reset_pc", pc, RST_PC);
    chk("reset_pred_taken", 32'(pred_taken), 32'd0);
    chk("reset_pred_target", pred_target, RST_PC + 32'd4);
    step(); chk("run_pc4", pc, 32'h4);
    step(); chk("run_pc8", pc, 32'h8);
    step(); chk("run_pcC", pc, 32'hC);
    chk("run_pred_taken", 32'(pred_taken), 32'd0);

    ex_br(32'h10, 32'h20, 1, 0, 32'h0);
    chk("cold_redirect", 32'(redirect), 32'd1);
    step(); chk("cold_pc", pc, 32'h30);
    goto_pc(32'h10);
    chk("cold_refetch_taken", 32'(pred_taken), 32'd1);
    chk("cold_refetch_target", pred_target, 32'h30);

    ex_br(32'h10, 32'h20, 1, 1, 32'h30);
    chk("train_no_redirect", 32'(redirect), 32'd0);
    step();
    ex_br(32'h10, 32'h20, 0, 1, 32'h30);
    chk("nt1_redirect", 32'(redirect), 32'd1);
    step(); chk("nt1_pc", pc, 32'h14);
    goto_pc(32'h10);
    chk("ctr2_pred_taken", 32'(pred_taken), 32'd1);
    ex_br(32'h10, 32'h20, 0, 1, 32'h30);
    chk("nt2_redirect", 32'(redirect), 32'd1);
    step(); chk("nt2_pc", pc, 32'h14);
    goto_pc(32'h10);
    chk("ctr1_pred_taken", 32'(pred_taken), 32'd0);
    chk("ctr1_pred_target", pred_target, 32'h30);

    ex_jmp(32'h40, 1, 32'h101, 32'h4);
    chk("jalr_misaligned0", 32'(misaligned), 32'd0);
    chk("jalr_redirect", 32'(redirect), 32'd1);
    step(); chk("jalr_pc", pc, 32'h104);
    ex_jmp(32'h44, 1, 32'h102, 32'h0);
    chk("jalr_misaligned1", 32'(misaligned), 32'd1);
    step(); chk("jalr_mis_pc", pc, 32'h102);

    stall = 1;
    ex_br(32'h80, 32'h180, 1, 0, 32'h0);
    chk("stall_redirect", 32'(redirect), 32'd1);
    step(); chk("stall_redirect_pc", pc, 32'h200);
    for (int k = 0; k < 3; k++) begin
      step(); chk("stall_hold", pc, 32'h200);
    end
    stall = 0;

    ex_br(32'hFFFF_FFF0, 32'h20, 1, 0, 32'h0);
    step(); chk("wrap_pc", pc, 32'h10);

    ex_jmp(32'h50, 0, 32'h0, 32'h100);
    chk("alias_alloc_redirect", 32'(redirect), 32'd1);
    step(); chk("alias_alloc_pc", pc, 32'h150);
    goto_pc(32'h10);
    chk("evicted_pred_taken", 32'(pred_taken), 32'd0);
    chk("evicted_pred_target", pred_target, 32'h14);
    goto_pc(32'h50);
    chk("alias_hit_taken", 32'(pred_taken), 32'd1);
    chk("alias_hit_target", pred_target, 32'h150);

    rst = 1;
    ex_br(32'h60, 32'h40, 1, 0, 32'h0);
    step();
    rst = 0;
    #1 chk("rst_over_redirect_pc", pc, RST_PC);
    goto_pc(32'h60);
    chk("rst_no_write_taken", 32'(pred_taken), 32'd0);
    chk("rst_no_write_target", pred_target, 32'h64);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Fetch-stage program counter register with a direct-mapped branch target buffer (BTB) and 2-bit saturating-counter direction prediction.
- Replaces the purely combinational next-PC selector.
- Each cycle it predicts the next fetch PC from the current PC.
- It accepts resolved control-flow outcomes from execute and redirects and flushes on a mispredict.
- It sits between instruction fetch and the execute-stage branch comparator.

Parameters:
- XLEN, 32: datapath and PC width.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- BTB_ENTRIES, 16: number of BTB entries. Power of two, 2..256.

Ports:
- clk  in  1: clock.
- rst  in  1: reset, synchronous active-high.
- stall  in  1: hold the PC (fetch back-pressure).
- pc  out  XLEN: current fetch PC (register).
- pred_taken  out  1: prediction for the instruction at pc.
- pred_target  out  XLEN: predicted target, valid when pred_taken=1.
- ex_valid  in  1: execute stage holds a valid instruction this cycle.
- ex_pc  in  XLEN: PC of the execute-stage instruction.
- ex_jump  in  1: JAL or JALR.
- ex_jalr  in  1: JALR (only meaningful with ex_jump).
- ex_branch  in  1: conditional branch.
- ex_cond  in  1: branch condition true.
- ex_rs1  in  XLEN: rs1 operand.
- ex_imm  in  XLEN: sign-extended immediate, byte offset, already scaled.
- ex_pred_taken  in  1: prediction carried down the pipe with this instruction.
- ex_pred_target  in  XLEN: target carried down the pipe with this instruction.
- redirect  out  1: mispredict detected this cycle; flush younger stages.
- misaligned  out  1: resolved taken target has bit[1] set.

Behaviour:
- Decided interface facts: one clock, clk; reset rst is synchronous and active-high.
- Index and tag:
  - IDX = log2(BTB_ENTRIES).
  - Index = addr[IDX+1:2]; tag = addr[XLEN-1:IDX+2].
  - Entry contents: valid, tag, target[XLEN-1:0], is_jump, ctr[1:0].
- Lookup (combinational on pc):
  - hit = valid && tag match.
  - pred_taken = hit && (is_jump || ctr[1]).
  - pred_target = entry target when hit, else pc+4.
- Resolution (combinational, ex_valid=1):
  - actual_taken = ex_jump || (ex_branch && ex_cond).
  - Target selection:
    - JALR: (ex_rs1+ex_imm) with bit0 cleared.
    - JAL or branch: ex_pc+ex_imm.
    - Not taken: ex_pc+4.
  - All adds are modulo 2^XLEN.
  - redirect = ex_valid && (actual_taken != ex_pred_taken || (actual_taken && target != ex_pred_target)).
  - redirect is 0 when ex_valid=0.
  - misaligned = ex_valid && actual_taken && target[1].
- PC update at posedge clk, priority order:
  1. rst: pc <= RESET_PC.
  2. redirect: pc <= resolved next PC. Redirect overrides stall.
  3. stall: pc holds.
  4. Otherwise: pc <= pred_taken ? pred_target : pc+4.
- BTB update at posedge, when ex_valid && (ex_jump || ex_branch) && !rst:
  - Taken and miss on ex_pc: allocate the entry (overwrite any existing). Set valid=1, tag, target, is_jump=ex_jump, ctr=2'b10.
  - Hit: target <= resolved target if taken; is_jump <= ex_jump. For a branch, ctr increments saturating at 3 when taken and decrements saturating at 0 when not taken.
  - Not taken and miss: no write.
  - The update is independent of stall.
- Same-cycle lookup and update of the same index: lookup returns pre-write contents; the new contents are visible the next cycle.
- Reset:
  - All BTB valid bits clear in one cycle; target and ctr contents are don't-care.
  - After reset: pc=RESET_PC, pred_taken=0, pred_target=RESET_PC+4.
  - redirect and misaligned follow their inputs (combinational); the bench holds ex_valid=0 during reset.
  - Reset asserted mid-operation discards any pending redirect and BTB write that cycle.
- Non-control instructions (ex_jump=ex_branch=0) with ex_pred_taken=1 (stale alias): redirect to ex_pc+4; no BTB write.
- misaligned does not alter the redirect; trap handling is outside this block.

Test Plan:
- Reset, then free-run with ex_valid=0: pc sequence 0x0, 0x4, 0x8, 0xC; pred_taken=0 throughout.
- Cold-BTB branch at ex_pc=0x10, ex_imm=0x20, ex_cond=1, ex_pred_taken=0: redirect=1 that cycle; next pc=0x30. Entry 4 gets target 0x30 and ctr=2. The next fetch of 0x10 gives pred_taken=1, pred_target=0x30.
- Loop branch trained to ctr=3, then not taken twice: first not-taken redirects to 0x14 and ctr drops to 2 (still predicts taken). Second not-taken redirects and ctr drops to 1. The next fetch of 0x10 gives pred_taken=0.
- JALR with ex_rs1=0x101, ex_imm=0x4: resolved target 0x104 (bit0 cleared); misaligned=0. With ex_rs1=0x102, ex_imm=0: target 0x102 and misaligned=1.
- stall=1 together with a mispredict redirect to 0x200: pc=0x200 next cycle. stall=1 with no redirect: pc holds for 3 cycles.
- Aliasing with BTB_ENTRIES=16: 0x10 and 0x50 share index 4. Allocating 0x50 evicts 0x10, so fetch of 0x10 misses. Also: rst asserted in the same cycle as a mispredict gives pc=RESET_PC and no entry written.
